msrv32_imm_ctrl: RTL and testbench
==================================

# msrv32_imm_ctrl

Decode-stage controller that sequences the msrv32 immediate generator. It accepts 32-bit instructions from fetch over a valid/ready handshake and classifies each opcode into the 3-bit immediate type. It registers the instruction and type so the immediate generator is driven from stable flops, and presents them downstream over a second valid/ready handshake. Sits between instruction fetch and execute; the immediate generator instance is fed directly from `instr_out` and `imm_type_out`.

## Interface
- No parameters.
- `clk_in`  input  1  core clock; all flops on rising edge.
- `rst_n_in`  input  1  asynchronous, active-low reset.
- `instr_in`  input  32  instruction word from fetch.
- `instr_valid_in`  input  1  fetch has a valid instruction.
- `instr_ready_out`  output  1  controller can accept `instr_in` this cycle.
- `flush_in`  input  1  synchronous flush; discards all held instructions.
- `instr_out`  output  25  held instruction bits [31:7], to immediate generator and execute.
- `imm_type_out`  output  3  immediate type, to immediate generator.
- `illegal_out`  output  1  held instruction has an unsupported or illegal opcode.
- `valid_out`  output  1  `instr_out`, `imm_type_out` and `illegal_out` are valid.
- `ready_in`  input  1  downstream accepts the output this cycle.

## Operation
- A transfer occurs on an edge where valid and ready are both 1, for either handshake.
- Opcode classification uses `instr_in[6:2]`:
  - 01100 (OP) -> 000 (R).
  - 00000 (LOAD), 00011 (MISC_MEM), 00100 (OP_IMM), 11001 (JALR) -> 001 (I).
  - 01000 (STORE) -> 010 (S).
  - 11000 (BRANCH) -> 011 (B).
  - 01101 (LUI), 00101 (AUIPC) -> 100 (U).
  - 11011 (JAL) -> 101 (J).
  - 11100 (SYSTEM) -> 110 (CSR) if `instr_in[14]`=1, else 001.
  - Any other opcode, or `instr_in[1:0]`≠2'b11 -> 111 with `illegal_out`=1. Illegal instructions still flow through the handshake.
- State machine, built with the skid buffer compiled in:
  - EMPTY: nothing held. Accept -> BUSY.
  - BUSY: output register valid. Accept with no drain -> FULL. Drain with no accept -> EMPTY. Accept with drain -> BUSY, output register reloaded.
  - FULL: output register and skid both valid; `instr_ready_out`=0. Drain -> BUSY, skid moves into the output register.
- `flush_in`=1 has top priority:
  - Next state is EMPTY; all valid bits are cleared.
  - Any instruction accepted in the same cycle is dropped.
  - Data registers are not cleared.
- Output data are stable while `valid_out`=1 and `ready_in`=0.

## Timing
- Reset values (asynchronous, immediate on `rst_n_in`=0): `valid_out`=0, `illegal_out`=0, `imm_type_out`=3'b000, `instr_out`=0, state EMPTY.
- `instr_ready_out` reset value: 1 with the skid buffer; 1 by derivation without it.
- Latency: an instruction accepted on edge N gives `valid_out`=1 with its data after edge N.
- Throughput: 1 instruction/cycle while `ready_in`=1.
- With the skid buffer, `instr_ready_out` is a flop output (= state≠FULL). It has no combinational path from `ready_in`.
- Reset asserted mid-operation discards all held instructions at once. There is no partial transfer.

## Configuration
- Macro: `MSRV32_IMM_CTRL_SKID_EN`.
- Defined:
  - Adds a one-entry skid buffer and the FULL state.
  - `instr_ready_out` is registered.
  - Sustains full throughput under any `ready_in` pattern.
- Undefined:
  - No skid buffer; only EMPTY and BUSY exist.
  - `instr_ready_out` = !`valid_out` || `ready_in` (combinational).
  - Latency, classification and flush behaviour are unchanged.

## Test plan
- Reset then stream of 0x00500093 (addi), 0x00112223 (sw), 0xFE000EE3 (beq), 0x123450B7 (lui), 0x008000EF (jal), 0x34029073 (csrrw) with `ready_in`=1:
  - `imm_type_out` = 001, 010, 011, 100, 101, 001 on consecutive cycles, each 1 cycle after accept.
  - `valid_out` stays 1 throughout.
- 0x3400D073 (csrrwi, funct3=101) -> 110. 0x0000007F -> 111 with `illegal_out`=1. 0x00000013 with bits[1:0] forced to 00 -> illegal.
- Backpressure, `ready_in`=0 for 3 cycles during a continuous stream:
  - With skid: FULL after 2 accepts, `instr_ready_out`=0, outputs frozen; order preserved after release, none lost or duplicated.
  - Without skid: `instr_ready_out` follows `ready_in`.
- `flush_in`=1 while FULL with a simultaneous accept:
  - Next cycle `valid_out`=0, `instr_ready_out`=1.
  - The next accepted instruction is the first one output.
- `rst_n_in` pulsed low mid-stream, off a clock edge -> `valid_out`=0 immediately, outputs at their reset values.
- Random valid/ready toggling for 10k cycles against a reference queue model -> zero ordering or classification mismatches.

Source files
------------

// File: rtl/msrv32_imm_ctrl.sv
// Decode-stage sequencer for the msrv32 immediate generator: classifies opcodes and holds them on a valid/ready pipe.
// Define MSRV32_IMM_CTRL_SKID_EN to add a one-entry skid buffer and a registered instr_ready_out.
//   state | meaning
//   EMPTY | nothing held
//   BUSY  | output register valid
//   FULL  | output register and skid both valid (skid build only)
module msrv32_imm_ctrl (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] instr_in,
  input  logic        instr_valid_in,
  output logic        instr_ready_out,
  input  logic        flush_in,
  output logic [24:0] instr_out,
  output logic [2:0]  imm_type_out,
  output logic        illegal_out,
  output logic        valid_out,
  input  logic        ready_in
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [24:0] instr_q, instr_d;
  logic [2:0]  type_q, type_d;
  logic        ill_q, ill_d;
  logic [2:0]  cls_type;
  logic        cls_ill;
  logic        accept, drain;

  always_comb begin
    cls_type = 3'b111;
    cls_ill  = 1'b0;
    unique case (instr_in[6:2])
      5'b01100:                               cls_type = 3'b000;
      5'b00000, 5'b00011, 5'b00100, 5'b11001: cls_type = 3'b001;
      5'b01000:                               cls_type = 3'b010;
      5'b11000:                               cls_type = 3'b011;
      5'b01101, 5'b00101:                     cls_type = 3'b100;
      5'b11011:                               cls_type = 3'b101;
      5'b11100:                               cls_type = instr_in[14] ? 3'b110 : 3'b001;
      default:                                cls_ill  = 1'b1;
    endcase
    if (instr_in[1:0] != 2'b11) cls_ill = 1'b1;
    if (cls_ill) cls_type = 3'b111;
  end

  assign valid_out    = (state_q != S_EMPTY);
  assign instr_out    = instr_q;
  assign imm_type_out = type_q;
  assign illegal_out  = ill_q;
  assign accept       = instr_valid_in && instr_ready_out;
  assign drain        = valid_out && ready_in;

`ifdef MSRV32_IMM_CTRL_SKID_EN
  logic [24:0] skid_instr_q, skid_instr_d;
  logic [2:0]  skid_type_q, skid_type_d;
  logic        skid_ill_q, skid_ill_d;
  logic        rdy_q;

  assign instr_ready_out = rdy_q;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    type_d       = type_q;
    ill_d        = ill_q;
    skid_instr_d = skid_instr_q;
    skid_type_d  = skid_type_q;
    skid_ill_d   = skid_ill_q;
    if (flush_in) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin
          state_d = S_BUSY;
          instr_d = instr_in[31:7];
          type_d  = cls_type;
          ill_d   = cls_ill;
        end
        S_BUSY: if (accept && !drain) begin
          state_d      = S_FULL;
          skid_instr_d = instr_in[31:7];
          skid_type_d  = cls_type;
          skid_ill_d   = cls_ill;
        end else if (accept) begin
          instr_d = instr_in[31:7];
          type_d  = cls_type;
          ill_d   = cls_ill;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
        S_FULL: if (drain) begin
          state_d = S_BUSY;
          instr_d = skid_instr_q;
          type_d  = skid_type_q;
          ill_d   = skid_ill_q;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdy_q        <= 1'b1;
      skid_instr_q <= '0;
      skid_type_q  <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      rdy_q        <= (state_d != S_FULL);
      skid_instr_q <= skid_instr_d;
      skid_type_q  <= skid_type_d;
      skid_ill_q   <= skid_ill_d;
    end
  end
`else
  assign instr_ready_out = !valid_out || ready_in;

  // Without a skid, an accept in BUSY always coincides with a drain.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    type_d  = type_q;
    ill_d   = ill_q;
    if (flush_in) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      state_d = S_BUSY;
      instr_d = instr_in[31:7];
      type_d  = cls_type;
      ill_d   = cls_ill;
    end else if (drain) begin
      state_d = S_EMPTY;
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_EMPTY;
      instr_q <= '0;
      type_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      type_q  <= type_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_msrv32_imm_ctrl.sv
// Scoreboard bench for msrv32_imm_ctrl: accepted instructions are queued with their expected
// classification and checked in order as the DUT presents them.
module tb_msrv32_imm_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [31:0] instr_in = '0;
  logic        instr_valid_in = 1'b0;
  logic        instr_ready_out;
  logic        flush_in = 1'b0;
  logic [24:0] instr_out;
  logic [2:0]  imm_type_out;
  logic        illegal_out;
  logic        valid_out;
  logic        ready_in = 1'b0;

  typedef struct {
    logic [24:0] instr;
    logic [2:0]  ty;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  msrv32_imm_ctrl dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .instr_in        (instr_in),
    .instr_valid_in  (instr_valid_in),
    .instr_ready_out (instr_ready_out),
    .flush_in        (flush_in),
    .instr_out       (instr_out),
    .imm_type_out    (imm_type_out),
    .illegal_out     (illegal_out),
    .valid_out       (valid_out),
    .ready_in        (ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference classification, straight from the opcode table.
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    int   op;
    e.instr = ins[31:7];
    e.ill   = 1'b0;
    op      = int'(ins[6:2]);
    if      (op == 12)                                      e.ty = 3'd0;
    else if (op == 0 || op == 3 || op == 4 || op == 25)     e.ty = 3'd1;
    else if (op == 8)                                       e.ty = 3'd2;
    else if (op == 24)                                      e.ty = 3'd3;
    else if (op == 13 || op == 5)                           e.ty = 3'd4;
    else if (op == 27)                                      e.ty = 3'd5;
    else if (op == 28)                                      e.ty = ins[14] ? 3'd6 : 3'd1;
    else                                                    e.ill = 1'b1;
    if (ins[1:0] != 2'b11) e.ill = 1'b1;
    if (e.ill) e.ty = 3'd7;
    return e;
  endfunction

  // Monitor: held-count checks and in-order data checks.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      chk("valid_out", {31'd0, valid_out}, {31'd0, q.size() != 0});
`ifdef MSRV32_IMM_CTRL_SKID_EN
      chk("ready_out", {31'd0, instr_ready_out}, {31'd0, q.size() < 2});
`else
      chk("ready_out", {31'd0, instr_ready_out}, {31'd0, (q.size() == 0) || ready_in});
`endif
      if (valid_out && q.size() != 0) begin
        chk("instr_out", {7'd0, instr_out}, {7'd0, q[0].instr});
        chk("imm_type", {29'd0, imm_type_out}, {29'd0, q[0].ty});
        chk("illegal", {31'd0, illegal_out}, {31'd0, q[0].ill});
        if (ready_in && !flush_in) void'(q.pop_front());
      end
    end
  end

  // Stimulus side of the scoreboard: record what the upcoming edge accepts.
  always @(negedge clk_in) begin
    #2;
    if (rst_n_in) begin
      if (flush_in) q.delete();
      else if (instr_valid_in && instr_ready_out) q.push_back(model(instr_in));
    end
  end

  task automatic step(input bit v, input logic [31:0] ins, input bit r, input bit f);
    @(posedge clk_in);
    #1;
    instr_valid_in = v;
    instr_in       = ins;
    ready_in       = r;
    flush_in       = f;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] ops [11];
    logic [31:0] w;
    ops = '{5'b01100, 5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b01000,
            5'b11000, 5'b01101, 5'b00101, 5'b11011, 5'b11100};
    w = $urandom;
    if ($urandom_range(0, 9) < 8) w[6:0] = {ops[$urandom_range(0, 10)], 2'b11};
    return w;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_instr"}, {7'd0, instr_out}, 32'd0);
    chk({tag, "_type"}, {29'd0, imm_type_out}, 32'd0);
    chk({tag, "_illegal"}, {31'd0, illegal_out}, 32'd0);
    chk({tag, "_ready"}, {31'd0, instr_ready_out}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] stream [6];
    logic [31:0] misc [3];
    stream = '{32'h00500093, 32'h00112223, 32'hFE000EE3, 32'h123450B7, 32'h008000EF, 32'h34029073};
    misc   = '{32'h3400D073, 32'h0000007F, 32'h00000010};

    #3;
    check_reset_values("reset");
    #14 rst_n_in = 1'b1;

    // Back-to-back stream, downstream always ready.
    foreach (stream[i]) step(1'b1, stream[i], 1'b1, 1'b0);
    foreach (misc[i]) step(1'b1, misc[i], 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure for 3 cycles during a continuous stream.
    step(1'b1, stream[0], 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) step(1'b1, stream[i], 1'b0, 1'b0);
    for (int i = 4; i < 6; i++) step(1'b1, stream[i], 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Fill up, then flush with a simultaneous offer.
    step(1'b1, stream[1], 1'b0, 1'b0);
    step(1'b1, stream[2], 1'b0, 1'b0);
    step(1'b1, stream[3], 1'b0, 1'b1);
    step(1'b1, stream[4], 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream, off the clock edge.
    step(1'b1, stream[0], 1'b0, 1'b0);
    step(1'b1, stream[5], 1'b0, 1'b0);
    #2 rst_n_in = 1'b0;
    #1;
    check_reset_values("midreset");
    q.delete();
    instr_valid_in = 1'b0;
    #13 rst_n_in = 1'b1;

    // Random valid/ready/flush traffic.
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 99) < 70, rand_instr(), $urandom_range(0, 99) < 60,
           $urandom_range(0, 199) == 0);

    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk_in);
    #3;
    chk("drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
